// File: rtl/rv_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_decode_pkg
// Description : Shared RV32I decode definitions.
//               - ALU operation encodings (ALU_*) consumed by the ALU
//               - opcode / funct3 / funct7 field values
//               - decoded-entry struct carried through the issue buffer
//               - issue buffer occupancy states
// Revision    : 1.0  initial release
// ============================================================================
package rv_decode_pkg;

    localparam int XLEN = 32;

    // ALU operation encodings shared with the ALU
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_NONE = 4'd15;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values for OP / OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]      alu_sel;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } dec_entry_t;

    // Value presented on the outputs while nothing is buffered
    localparam dec_entry_t ENTRY_IDLE = '{
        alu_sel: ALU_NONE,
        op1:     '0,
        op2:     '0,
        rd:      '0,
        rd_we:   1'b0,
        illegal: 1'b0,
        pc:      '0
    };

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } issue_state_e;

endpackage : rv_decode_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Purely combinational RV32I decode of one instruction and its
//               register operands into an ALU-ready entry.
//   i_instr     in   32  instruction word
//   i_pc        in   32  instruction PC
//   i_rs1_data  in   32  x[rs1]
//   i_rs2_data  in   32  x[rs2]
//   o_entry     out  struct  decoded entry {alu_sel,op1,op2,rd,rd_we,illegal,pc}
// Revision    : 1.0  initial release
// ============================================================================
module alu_op_decode
    import rv_decode_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output dec_entry_t  o_entry
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic [31:0] w_shamt;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_rd     = i_instr[11:7];
    assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_u  = {i_instr[31:12], 12'b0};
    assign w_shamt  = {27'b0, i_instr[24:20]};

    logic [3:0]  w_sel;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic        w_writes;
    logic        w_illegal;

    always_comb begin
        w_sel     = ALU_NONE;
        w_op1     = '0;
        w_op2     = '0;
        w_writes  = 1'b0;
        w_illegal = 1'b0;

        unique case (w_opcode)
            OPC_OP: begin
                w_op1    = i_rs1_data;
                w_op2    = i_rs2_data;
                w_writes = 1'b1;
                // Only ADD/SUB and SRL/SRA have an alternate funct7
                unique case (w_funct3)
                    F3_ADD: begin
                        if (w_funct7 == F7_BASE)     w_sel = ALU_ADD;
                        else if (w_funct7 == F7_ALT) w_sel = ALU_SUB;
                        else                         w_illegal = 1'b1;
                    end
                    F3_SR: begin
                        // ALU shifts by the full op2, so trim to 5 bits here
                        w_op2 = {27'b0, i_rs2_data[4:0]};
                        if (w_funct7 == F7_BASE)     w_sel = ALU_SRL;
                        else if (w_funct7 == F7_ALT) w_sel = ALU_SRA;
                        else                         w_illegal = 1'b1;
                    end
                    default: begin
                        w_illegal = (w_funct7 != F7_BASE);
                        unique case (w_funct3)
                            F3_SLL: begin
                                w_sel = ALU_SLL;
                                w_op2 = {27'b0, i_rs2_data[4:0]};
                            end
                            F3_SLT:  w_sel = ALU_SLT;
                            F3_SLTU: w_sel = ALU_SLTU;
                            F3_XOR:  w_sel = ALU_XOR;
                            F3_OR:   w_sel = ALU_OR;
                            default: w_sel = ALU_AND;
                        endcase
                    end
                endcase
            end
            OPC_OP_IMM: begin
                w_op1    = i_rs1_data;
                w_op2    = w_imm_i;
                w_writes = 1'b1;
                unique case (w_funct3)
                    F3_ADD:  w_sel = ALU_ADD;
                    F3_SLT:  w_sel = ALU_SLT;
                    F3_SLTU: w_sel = ALU_SLTU;
                    F3_XOR:  w_sel = ALU_XOR;
                    F3_OR:   w_sel = ALU_OR;
                    F3_AND:  w_sel = ALU_AND;
                    F3_SLL: begin
                        w_sel     = ALU_SLL;
                        w_op2     = w_shamt;
                        w_illegal = (w_funct7 != F7_BASE);
                    end
                    default: begin
                        // SRLI/SRAI: only bit 30 distinguishes them
                        w_sel = i_instr[30] ? ALU_SRA : ALU_SRL;
                        w_op2 = w_shamt;
                    end
                endcase
            end
            OPC_LUI: begin
                w_sel    = ALU_LUI;
                w_op2    = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_AUIPC: begin
                w_sel    = ALU_ADD;
                w_op1    = i_pc;
                w_op2    = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU computes the link value; target is resolved elsewhere
                w_sel    = ALU_ADD;
                w_op1    = i_pc;
                w_op2    = 32'd4;
                w_writes = 1'b1;
            end
            OPC_LOAD: begin
                w_sel    = ALU_ADD;
                w_op1    = i_rs1_data;
                w_op2    = w_imm_i;
                w_writes = 1'b1;
            end
            OPC_STORE: begin
                w_sel = ALU_ADD;
                w_op1 = i_rs1_data;
                w_op2 = w_imm_s;
            end
            OPC_BRANCH: begin
                w_op1 = i_rs1_data;
                w_op2 = i_rs2_data;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Illegal entries are neutralised so nothing downstream acts on them.
    // rd is reported only for instructions that write back.
    always_comb begin
        o_entry    = ENTRY_IDLE;
        o_entry.pc = i_pc;
        if (w_illegal) begin
            o_entry.illegal = 1'b1;
        end else begin
            o_entry.alu_sel = w_sel;
            o_entry.op1     = w_op1;
            o_entry.op2     = w_op2;
            o_entry.rd      = w_writes ? w_rd : 5'd0;
            o_entry.rd_we   = w_writes && (w_rd != 5'd0);
        end
    end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Decode/issue stage in front of the ALU. Decodes an RV32I
//               instruction with its register read data and holds the result
//               in a 2-entry skid buffer with valid/ready on both sides.
//   clk, rst                        clock, synchronous active-high reset
//   flush                           drop buffered and incoming entries
//   in_valid/in_ready               upstream handshake
//   in_instr, in_pc, in_rs*_data    instruction, PC, operands
//   out_valid/out_ready             downstream handshake
//   out_alu_sel/op1/op2/rd/rd_we/illegal/pc   issued entry (from main reg)
// Revision    : 1.0  initial release
// ============================================================================
module alu_issue
    import rv_decode_pkg::*;
#(
    parameter int DW = 32,  // must be 32 (RV32I)
    parameter int AW = 32   // must be 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [AW-1:0] in_pc,
    input  logic [DW-1:0] in_rs1_data,
    input  logic [DW-1:0] in_rs2_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_alu_sel,
    output logic [DW-1:0] out_op1,
    output logic [DW-1:0] out_op2,
    output logic [4:0]    out_rd,
    output logic          out_rd_we,
    output logic          out_illegal,
    output logic [AW-1:0] out_pc
);

    issue_state_e state_q, state_d;
    dec_entry_t   main_q, main_d;
    dec_entry_t   skid_q, skid_d;
    dec_entry_t   w_dec;
    logic         w_accept;
    logic         w_pop;

    alu_op_decode u_decode (
        .i_instr    (in_instr),
        .i_pc       (in_pc),
        .i_rs1_data (in_rs1_data),
        .i_rs2_data (in_rs2_data),
        .o_entry    (w_dec)
    );

    // Both handshake outputs come straight from state, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = ENTRY_IDLE;
            skid_d  = ENTRY_IDLE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        main_d  = w_dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        main_d = w_dec;
                    end else if (w_accept) begin
                        skid_d  = w_dec;
                        state_d = ST_TWO;
                    end else if (w_pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can happen
                    if (w_pop) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= ENTRY_IDLE;
            skid_q  <= ENTRY_IDLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_alu_sel = main_q.alu_sel;
    assign out_op1     = main_q.op1;
    assign out_op2     = main_q.op2;
    assign out_rd      = main_q.rd;
    assign out_rd_we   = main_q.rd_we;
    assign out_illegal = main_q.illegal;
    assign out_pc      = main_q.pc;

endmodule : alu_issue
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Self-checking bench for alu_issue: decode vector table,
//               backpressure / flush / reset sequences, and randomized
//               traffic against a queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue;
    import rv_decode_pkg::*;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
    logic [3:0]  out_alu_sel;
    logic [31:0] out_op1, out_op2, out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue #(.DW(32), .AW(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_sel(out_alu_sel), .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal),
        .out_pc(out_pc)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t dut_out();
        exp_t e;
        e.sel = out_alu_sel; e.op1 = out_op1; e.op2 = out_op2; e.rd = out_rd;
        e.we = out_rd_we; e.ill = out_illegal; e.pc = out_pc;
        return e;
    endfunction

    function automatic exp_t mk(input logic [3:0] sel, input logic [31:0] op1, op2,
                                input logic [4:0] rd, input logic we, ill,
                                input logic [31:0] pc);
        exp_t e;
        e.sel = sel; e.op1 = op1; e.op2 = op2; e.rd = rd; e.we = we; e.ill = ill; e.pc = pc;
        return e;
    endfunction

    function automatic logic [3:0] base_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return alt ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Reference decode from the instruction-set rules
    function automatic exp_t ref_decode(input logic [31:0] ins, rs1, rs2, pc);
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        logic [31:0] immi = 32'($signed(ins[31:20]));
        logic [31:0] imms = 32'($signed({ins[31:25], ins[11:7]}));
        logic [31:0] immu = ins & 32'hFFFF_F000;
        logic        legal = 1'b1;
        logic        wr = 1'b0;
        logic [3:0]  sel = ALU_NONE;
        logic [31:0] a = 0, b = 0;
        case (opc)
            7'b0110011: begin
                a = rs1; b = rs2; wr = 1'b1;
                sel = base_sel(f3, f7 == 7'h20);
                if (f3 == 3'd1 || f3 == 3'd5) b = rs2 % 32;
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'b0010011: begin
                a = rs1; b = immi; wr = 1'b1;
                sel = base_sel(f3, f3 == 3'd5 && ins[30]);
                if (f3 == 3'd1 || f3 == 3'd5) b = 32'(ins[24:20]);
                if (f3 == 3'd1 && f7 != 7'h00) legal = 1'b0;
            end
            7'b0110111: begin sel = ALU_LUI; b = immu; wr = 1'b1; end
            7'b0010111: begin sel = ALU_ADD; a = pc; b = immu; wr = 1'b1; end
            7'b1101111, 7'b1100111: begin sel = ALU_ADD; a = pc; b = 4; wr = 1'b1; end
            7'b0000011: begin sel = ALU_ADD; a = rs1; b = immi; wr = 1'b1; end
            7'b0100011: begin sel = ALU_ADD; a = rs1; b = imms; end
            7'b1100011: begin a = rs1; b = rs2; end
            default: legal = 1'b0;
        endcase
        if (!legal) return mk(ALU_NONE, 0, 0, 0, 1'b0, 1'b1, pc);
        return mk(sel, a, b, wr ? ins[11:7] : 5'd0, wr && ins[11:7] != 0, 1'b0, pc);
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, rs1, rs2, pc);
        in_valid = v; in_instr = ins; in_rs1_data = rs1; in_rs2_data = rs2; in_pc = pc;
    endtask

    localparam int NV = 14;
    vec_t vecs[NV];
    exp_t q[$];
    exp_t ea, eb, ec;
    logic [6:0] opcs[9];

    initial begin
        vecs[0]  = '{32'h002081B3, 5, 7, 32'h100, mk(ALU_ADD, 5, 7, 3, 1, 0, 32'h100)};
        vecs[1]  = '{32'h40335293, 32'h8000_0000, 0, 32'h104, mk(ALU_SRA, 32'h8000_0000, 3, 5, 1, 0, 32'h104)};
        vecs[2]  = '{32'h003110B3, 32'hA, 32'h23, 32'h108, mk(ALU_SLL, 32'hA, 3, 1, 1, 0, 32'h108)};
        vecs[3]  = '{32'h123450B7, 9, 9, 32'h10C, mk(ALU_LUI, 0, 32'h1234_5000, 1, 1, 0, 32'h10C)};
        vecs[4]  = '{32'h12345037, 9, 9, 32'h110, mk(ALU_LUI, 0, 32'h1234_5000, 0, 0, 0, 32'h110)};
        vecs[5]  = '{32'hFFFFFFFF, 9, 9, 32'h114, mk(ALU_NONE, 0, 0, 0, 0, 1, 32'h114)};
        vecs[6]  = '{32'h40628233, 10, 3, 32'h118, mk(ALU_SUB, 10, 3, 4, 1, 0, 32'h118)};
        vecs[7]  = '{32'hFFF00093, 0, 0, 32'h11C, mk(ALU_ADD, 0, 32'hFFFF_FFFF, 1, 1, 0, 32'h11C)};
        vecs[8]  = '{32'h0020A423, 32'h100, 5, 32'h120, mk(ALU_ADD, 32'h100, 8, 0, 0, 0, 32'h120)};
        vecs[9]  = '{32'h00208463, 11, 12, 32'h124, mk(ALU_NONE, 11, 12, 0, 0, 0, 32'h124)};
        vecs[10] = '{32'h000000EF, 1, 2, 32'h1000, mk(ALU_ADD, 32'h1000, 4, 1, 1, 0, 32'h1000)};
        vecs[11] = '{32'h00001117, 1, 2, 32'h2000, mk(ALU_ADD, 32'h2000, 32'h1000, 2, 1, 0, 32'h2000)};
        vecs[12] = '{32'h022081B3, 5, 7, 32'h130, mk(ALU_NONE, 0, 0, 0, 0, 1, 32'h130)};
        vecs[13] = '{32'h0040A283, 32'h40, 0, 32'h134, mk(ALU_ADD, 32'h40, 4, 5, 1, 0, 32'h134)};
        opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                 7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};

        // ---------------- reset ----------------
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset outputs", dut_out(), mk(ALU_NONE, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        // ---------------- decode table ----------------
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].pc);
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), out_valid, 1);
            chk($sformatf("vec%0d entry", i), dut_out(), vecs[i].exp);
        end
        drive(1'b0, 0, 0, 0, 0);
        @(negedge clk);
        chk("drain out_valid", out_valid, 0);

        // ---------------- backpressure: 3 offered, 2 fit ----------------
        ea = ref_decode(32'h00100093, 0, 0, 32'hA0);
        eb = ref_decode(32'h00200093, 0, 0, 32'hA4);
        ec = ref_decode(32'h00300093, 0, 0, 32'hA8);
        out_ready = 1'b0;
        chk("bp in_ready0", in_ready, 1);
        drive(1'b1, 32'h00100093, 0, 0, 32'hA0);
        @(negedge clk);
        chk("bp A first", dut_out(), ea);
        chk("bp in_ready1", in_ready, 1);
        drive(1'b1, 32'h00200093, 0, 0, 32'hA4);
        @(negedge clk);
        chk("bp in_ready full", in_ready, 0);
        chk("bp A stable", dut_out(), ea);
        drive(1'b1, 32'h00300093, 0, 0, 32'hA8);
        @(negedge clk);
        chk("bp in_ready still full", in_ready, 0);
        chk("bp A stable2", dut_out(), ea);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp B second", dut_out(), eb);
        chk("bp in_ready reopened", in_ready, 1);
        @(negedge clk);
        chk("bp C third", dut_out(), ec);
        chk("bp C valid", out_valid, 1);
        drive(1'b0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bp empty", out_valid, 0);

        // ---------------- flush while full ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 0, 0, 32'hB0);
        @(negedge clk);
        drive(1'b1, 32'h00200093, 0, 0, 32'hB4);
        @(negedge clk);
        chk("fl full", in_ready, 0);
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 32'h00300093, 0, 0, 32'hB8);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        chk("fl out_valid", out_valid, 0);
        chk("fl in_ready", in_ready, 1);
        @(negedge clk);
        chk("fl entry absent", out_valid, 0);

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 5, 7, 32'hC0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'h40628233, 1, 2, 32'hC4);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst outputs", dut_out(), mk(ALU_NONE, 0, 0, 0, 0, 0, 0));

        // ---------------- randomized traffic ----------------
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [31:0] ins, r1, r2, pc;
            logic        v, fl, rdy, acc, pop;
            int          idx, r;
            @(negedge clk);
            chk("rnd in_ready", in_ready, (q.size() < 2));
            chk("rnd out_valid", out_valid, (q.size() > 0));
            if (q.size() > 0) chk("rnd entry", dut_out(), q[0]);

            ins = $urandom;
            idx = $urandom_range(0, 10);
            if (idx < 9) ins[6:0] = opcs[idx];
            r = $urandom_range(0, 3);
            if (r == 0) ins[31:25] = 7'h00;
            else if (r == 1) ins[31:25] = 7'h20;
            r1 = $urandom; r2 = $urandom; pc = $urandom & 32'hFFFF_FFFC;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            drive(v, ins, r1, r2, pc);
            out_ready = rdy;
            flush = fl;

            acc = v && (q.size() < 2);
            pop = rdy && (q.size() > 0);
            if (fl) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(ref_decode(ins, r1, r2, pc));
            end
        end
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_issue
`default_nettype wire
